// File: rtl/dk3_input_pkg.sv
// dk3_input_pkg: scan codes, key/joystick bit indices and coin FSM states shared by the input stage
package dk3_input_pkg;
   typedef enum logic [1:0] {IDLE, PULSE, GAP} coin_state_e;
   localparam int J_R = 0, J_L = 1, J_D = 2, J_U = 3, J_JUMP = 4, J_START1 = 5, J_START2 = 6, J_COIN = 7;
   localparam int K_NUM = 14;
   localparam logic [3:0] K_R1 = 4'd0, K_L1 = 4'd1, K_D1 = 4'd2, K_U1 = 4'd3, K_F1 = 4'd4, K_S1 = 4'd5,
                          K_S2 = 4'd6, K_COIN = 4'd7, K_R2 = 4'd8, K_L2 = 4'd9, K_D2 = 4'd10, K_U2 = 4'd11,
                          K_F2 = 4'd12, K_TEST = 4'd13, K_NONE = 4'd15;
   localparam logic [7:0] SC_UP = 8'h75, SC_DOWN = 8'h72, SC_LEFT = 8'h6B, SC_RIGHT = 8'h74;
   localparam logic [8:0] SC_FIRE1_A = 9'h029, SC_FIRE1_B = 9'h014, SC_START1_A = 9'h005, SC_START1_B = 9'h016,
                          SC_START2_A = 9'h006, SC_START2_B = 9'h01E, SC_COIN_A = 9'h02E, SC_COIN_B = 9'h036,
                          SC_UP2 = 9'h02D, SC_DOWN2 = 9'h02B, SC_LEFT2 = 9'h023, SC_RIGHT2 = 9'h034,
                          SC_FIRE2 = 9'h01C, SC_TEST = 9'h02C;

   // Arrow keys ignore the extended bit; everything else matches all nine bits.
   function automatic logic [3:0] key_idx(input logic [8:0] code);
      logic [3:0] idx;
      case (code)
         SC_FIRE1_A, SC_FIRE1_B:   idx = K_F1;
         SC_START1_A, SC_START1_B: idx = K_S1;
         SC_START2_A, SC_START2_B: idx = K_S2;
         SC_COIN_A, SC_COIN_B:     idx = K_COIN;
         SC_UP2:                   idx = K_U2;
         SC_DOWN2:                 idx = K_D2;
         SC_LEFT2:                 idx = K_L2;
         SC_RIGHT2:                idx = K_R2;
         SC_FIRE2:                 idx = K_F2;
         SC_TEST:                  idx = K_TEST;
         default:                  idx = K_NONE;
      endcase
      case (code[7:0])
         SC_UP:    idx = K_U1;
         SC_DOWN:  idx = K_D1;
         SC_LEFT:  idx = K_L1;
         SC_RIGHT: idx = K_R1;
         default:  ;
      endcase
      return idx;
   endfunction
endpackage

// File: rtl/dk3_joy_socd.sv
// dk3_joy_socd: per-player last-pressed-wins resolution of opposing directions
// clk, rst_n (async, active low); i_dir/o_dir [3:0] = {U, D, L, R}, o_dir valid off the in1 stage
module dk3_joy_socd
   import dk3_input_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] i_dir,
   output logic [3:0] o_dir
);
   logic [3:0] in1_q, in1_d, in2_q, in2_d, nw;
   logic [1:0] last_h_q, last_h_d, last_v_q, last_v_d;

   always_comb begin
      in1_d = i_dir;
      in2_d = in1_q;
      nw = in1_q & ~in2_q;
      // L and U take the latch when both directions of an axis are new together
      last_h_d = nw[J_L] ? 2'b10 : nw[J_R] ? 2'b01 : last_h_q;
      last_v_d = nw[J_U] ? 2'b10 : nw[J_D] ? 2'b01 : last_v_q;
      o_dir = {&in1_q[3:2] ? last_v_q : in1_q[3:2], &in1_q[1:0] ? last_h_q : in1_q[1:0]};
   end

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         in1_q <= '0;
         in2_q <= '0;
         last_h_q <= '0;
         last_v_q <= '0;
      end else begin
         in1_q <= in1_d;
         in2_q <= in2_d;
         last_h_q <= last_h_d;
         last_v_q <= last_v_d;
      end
endmodule

// File: rtl/dk3_input_ctl.sv
// dk3_input_ctl: PS/2 + joystick conditioning into the active-low DK3 switch bytes
// I_CLK_24M, I_RESETn (async, active low); I_PS2_KEY {toggle, pressed, code[8:0]};
// I_JOY0/I_JOY1 [0]R [1]L [2]D [3]U [4]jump [5]start1 [6]start2 [7]coin; I_ROTATE remaps directions;
// O_SW1/O_SW2 registered active-low switch bytes; O_COIN_BUSY coin shaper active
module dk3_input_ctl
   import dk3_input_pkg::*;
#(
   parameter int COIN_PULSE_CYC = 2457600,
   parameter int COIN_GAP_CYC   = 2457600
) (
   input  logic        I_CLK_24M,
   input  logic        I_RESETn,
   input  logic [10:0] I_PS2_KEY,
   input  logic [15:0] I_JOY0,
   input  logic [15:0] I_JOY1,
   input  logic        I_ROTATE,
   output logic [7:0]  O_SW1,
   output logic [7:0]  O_SW2,
   output logic        O_COIN_BUSY
);
   localparam int CNT_MAX = (COIN_PULSE_CYC > COIN_GAP_CYC) ? COIN_PULSE_CYC : COIN_GAP_CYC;
   localparam int CW = $clog2(CNT_MAX + 1);
   localparam logic [CW-1:0] PULSE_END = CW'(COIN_PULSE_CYC - 1);
   localparam logic [CW-1:0] GAP_END = CW'(COIN_GAP_CYC - 1);

   logic tog_q, tog_d, raw1_q, raw1_d, raw2_q, raw2_d, pend_q, pend_d, busy_q, busy_d;
   logic rise, pulse_done, gap_done, unused;
   logic [K_NUM-1:0] keys_q, keys_d;
   logic [4:0] btn_q, btn_d;
   logic [3:0] idx, dir0_raw, dir1_raw, dir0, dir1;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [7:0] sw1_q, sw1_d, sw2_q, sw2_d;
   coin_state_e state_q, state_d;

   assign unused = ^{I_JOY0[15:8], I_JOY1[15:8]};

   function automatic logic [3:0] rot(input logic [3:0] d, input logic r);
      return r ? {d[J_L], d[J_R], d[J_D], d[J_U]} : d;
   endfunction

   dk3_joy_socd u_socd0 (.clk(I_CLK_24M), .rst_n(I_RESETn), .i_dir(dir0_raw), .o_dir(dir0));
   dk3_joy_socd u_socd1 (.clk(I_CLK_24M), .rst_n(I_RESETn), .i_dir(dir1_raw), .o_dir(dir1));

   always_comb begin
      idx = key_idx(I_PS2_KEY[8:0]);
      tog_d = I_PS2_KEY[10];
      keys_d = keys_q;
      if (tog_d != tog_q && idx != K_NONE) keys_d[idx] = I_PS2_KEY[9];
      dir0_raw = rot(I_JOY0[3:0] | keys_q[K_U1:K_R1], I_ROTATE);
      dir1_raw = rot(I_JOY1[3:0] | keys_q[K_U2:K_R2], I_ROTATE);
      // buttons take one stage here to line up with the SOCD in1 stage
      btn_d = {keys_q[K_TEST],
               keys_q[K_S2] | I_JOY0[J_START2] | I_JOY1[J_START2],
               keys_q[K_S1] | I_JOY0[J_START1] | I_JOY1[J_START1],
               keys_q[K_F2] | I_JOY1[J_JUMP],
               keys_q[K_F1] | I_JOY0[J_JUMP]};
      raw1_d = I_JOY0[J_COIN] | I_JOY1[J_COIN] | keys_q[K_COIN];
      raw2_d = raw1_q;
      rise = raw1_q & ~raw2_q;
      pulse_done = cnt_q == PULSE_END;
      gap_done = cnt_q == GAP_END;
      state_d = state_q;
      cnt_d = '0;
      pend_d = pend_q;
      case (state_q)
         IDLE: state_d = rise ? PULSE : IDLE;
         PULSE: begin
            pend_d = pend_q | rise;
            state_d = pulse_done ? GAP : PULSE;
            cnt_d = pulse_done ? '0 : cnt_q + 1'b1;
         end
         GAP: begin
            pend_d = !gap_done & (pend_q | rise);
            state_d = !gap_done ? GAP : (pend_q | rise) ? PULSE : IDLE;
            cnt_d = gap_done ? '0 : cnt_q + 1'b1;
         end
         default: state_d = IDLE;
      endcase
      busy_d = state_d != IDLE;
      sw1_d = ~{btn_q[4], btn_q[3], btn_q[2], btn_q[0], dir0[J_D], dir0[J_U], dir0[J_L], dir0[J_R]};
      sw2_d = ~{2'b00, state_q == PULSE, btn_q[1], dir1[J_D], dir1[J_U], dir1[J_L], dir1[J_R]};
   end

   // The coin edge detector resets to "held" so a coin held through reset cannot re-trigger.
   always_ff @(posedge I_CLK_24M or negedge I_RESETn)
      if (!I_RESETn) begin
         tog_q <= 1'b0;
         keys_q <= '0;
         btn_q <= '0;
         raw1_q <= 1'b1;
         raw2_q <= 1'b1;
         state_q <= IDLE;
         cnt_q <= '0;
         pend_q <= 1'b0;
         busy_q <= 1'b0;
         sw1_q <= 8'hFF;
         sw2_q <= 8'hFF;
      end else begin
         tog_q <= tog_d;
         keys_q <= keys_d;
         btn_q <= btn_d;
         raw1_q <= raw1_d;
         raw2_q <= raw2_d;
         state_q <= state_d;
         cnt_q <= cnt_d;
         pend_q <= pend_d;
         busy_q <= busy_d;
         sw1_q <= sw1_d;
         sw2_q <= sw2_d;
      end

   assign O_SW1 = sw1_q;
   assign O_SW2 = sw2_q;
   assign O_COIN_BUSY = busy_q;
endmodule

// File: tb/tb_dk3_input_ctl.sv
// tb_dk3_input_ctl: vector table plus coin/reset sequences, checked through a cycle-stamped scoreboard
module tb_dk3_input_ctl;
   typedef struct {
      string name;
      logic [10:0] ps2;
      logic [15:0] j0, j1;
      logic rot;
      int lat;
      logic [7:0] sw1, sw2;
   } vec_t;
   typedef struct {
      string name;
      int due;
      logic [7:0] sw1, sw2;
      logic busy;
   } exp_t;

   logic clk = 1'b0, rst_n = 1'b1, rot = 1'b0, busy;
   logic [10:0] ps2 = '0;
   logic [15:0] j0 = '0, j1 = '0;
   logic [7:0] sw1, sw2;
   vec_t vecs[$];
   exp_t exp_q[$];
   int cyc = 0, checks = 0, errors = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   dk3_input_ctl #(.COIN_PULSE_CYC(8), .COIN_GAP_CYC(4)) dut (
      .I_CLK_24M(clk), .I_RESETn(rst_n), .I_PS2_KEY(ps2), .I_JOY0(j0), .I_JOY1(j1),
      .I_ROTATE(rot), .O_SW1(sw1), .O_SW2(sw2), .O_COIN_BUSY(busy)
   );

   task automatic chk(input string n, input logic [7:0] got, input logic [7:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %h expected %h", n, got, want);
      end
   endtask

   task automatic push(input string n, input int lat, input logic [7:0] s1, input logic [7:0] s2, input logic b);
      exp_q.push_back('{n, cyc + lat, s1, s2, b});
   endtask

   task automatic step(input int n);
      exp_t e;
      repeat (n) begin
         @(negedge clk);
         while (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
            e = exp_q.pop_front();
            if (e.due < cyc) begin
               checks++;
               errors++;
               $display("FAIL %s: checked at cycle %0d expected cycle %0d", e.name, cyc, e.due);
            end else begin
               chk({e.name, " sw1"}, sw1, e.sw1);
               chk({e.name, " sw2"}, sw2, e.sw2);
               chk({e.name, " busy"}, {7'd0, busy}, {7'd0, e.busy});
            end
         end
      end
   endtask

   task automatic push_coin(input string n, input int len, input int p1s, input int p1e,
                            input int p2s, input int p2e, input int be);
      for (int k = 1; k <= len; k++)
         push($sformatf("%s k%0d", n, k), k, 8'hFF,
              ((k >= p1s && k <= p1e) || (k >= p2s && k <= p2e)) ? 8'hDF : 8'hFF, k >= 2 && k <= be);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      chk("reset sw1", sw1, 8'hFF);
      chk("reset sw2", sw2, 8'hFF);
      chk("reset busy", {7'd0, busy}, 8'h00);
      step(2);
      rst_n = 1'b1;
   endtask

   function automatic void add(string n, logic t, logic p, logic [8:0] c, logic [15:0] a, logic [15:0] b,
                               logic r, int l, logic [7:0] s1, logic [7:0] s2);
      vecs.push_back('{n, {t, p, c}, a, b, r, l, s1, s2});
   endfunction

   initial begin
      #2;
      do_reset();
      add("idle",          0, 0, 9'h000, 16'h0000, 16'h0000, 0, 2, 8'hFF, 8'hFF);
      add("key_fire1",     1, 1, 9'h029, 16'h0000, 16'h0000, 0, 3, 8'hEF, 8'hFF);
      add("key_fire1_rel", 0, 0, 9'h029, 16'h0000, 16'h0000, 0, 3, 8'hFF, 8'hFF);
      add("joy_r",         0, 0, 9'h029, 16'h0001, 16'h0000, 0, 2, 8'hFE, 8'hFF);
      add("joy_rl",        0, 0, 9'h029, 16'h0003, 16'h0000, 0, 3, 8'hFD, 8'hFF);
      add("joy_rl_rel_l",  0, 0, 9'h029, 16'h0001, 16'h0000, 0, 2, 8'hFE, 8'hFF);
      add("joy_none",      0, 0, 9'h029, 16'h0000, 16'h0000, 0, 2, 8'hFF, 8'hFF);
      add("rot_l_up",      0, 0, 9'h029, 16'h0002, 16'h0000, 1, 2, 8'hFB, 8'hFF);
      add("rot_r_down",    0, 0, 9'h029, 16'h0001, 16'h0000, 1, 2, 8'hF7, 8'hFF);
      add("rot_u_right",   0, 0, 9'h029, 16'h0008, 16'h0000, 1, 2, 8'hFE, 8'hFF);
      add("joy1_down",     0, 0, 9'h029, 16'h0000, 16'h0004, 0, 2, 8'hFF, 8'hF7);
      add("joy1_fire2",    0, 0, 9'h029, 16'h0000, 16'h0010, 0, 2, 8'hFF, 8'hEF);
      add("joy1_start1",   0, 0, 9'h029, 16'h0000, 16'h0020, 0, 2, 8'hDF, 8'hFF);
      add("joy0_start2",   0, 0, 9'h029, 16'h0040, 16'h0000, 0, 2, 8'hBF, 8'hFF);
      add("key_test",      1, 1, 9'h02C, 16'h0000, 16'h0000, 0, 3, 8'h7F, 8'hFF);
      add("key_test_rel",  0, 0, 9'h02C, 16'h0000, 16'h0000, 0, 3, 8'hFF, 8'hFF);
      add("key_ext_up",    1, 1, 9'h175, 16'h0000, 16'h0000, 0, 3, 8'hFB, 8'hFF);
      add("key_up_rel",    0, 0, 9'h075, 16'h0000, 16'h0000, 0, 3, 8'hFF, 8'hFF);
      add("key_left2",     1, 1, 9'h023, 16'h0000, 16'h0000, 0, 3, 8'hFF, 8'hFD);
      add("key_unmapped",  0, 1, 9'h0FF, 16'h0000, 16'h0000, 0, 3, 8'hFF, 8'hFD);
      add("key_left2_rel", 1, 0, 9'h023, 16'h0000, 16'h0000, 0, 3, 8'hFF, 8'hFF);
      add("key_start1",    0, 1, 9'h016, 16'h0000, 16'h0000, 0, 3, 8'hDF, 8'hFF);
      add("key_start1_rel",1, 0, 9'h005, 16'h0000, 16'h0000, 0, 3, 8'hFF, 8'hFF);
      foreach (vecs[i]) begin
         ps2 = vecs[i].ps2;
         j0 = vecs[i].j0;
         j1 = vecs[i].j1;
         rot = vecs[i].rot;
         push(vecs[i].name, vecs[i].lat, vecs[i].sw1, vecs[i].sw2, 1'b0);
         step(5);
      end
      j0 = 16'h0003;
      do_reset();
      push("both_after_reset_e2", 2, 8'hFF, 8'hFF, 1'b0);
      push("both_after_reset_e3", 3, 8'hFD, 8'hFF, 1'b0);
      step(5);
      j0 = 16'h0000;
      step(4);
      push_coin("coin_hold", 30, 3, 10, 0, -1, 13);
      j1 = 16'h0080;
      step(30);
      j1 = 16'h0000;
      step(4);
      push_coin("coin_triple", 30, 3, 10, 15, 22, 25);
      j1 = 16'h0080;
      for (int k = 1; k <= 30; k++) begin
         step(1);
         if (k <= 5) j1[7] = (k % 2 == 0);
      end
      step(2);
      j1 = 16'h0080;
      step(5);
      do_reset();
      push_coin("coin_after_reset", 12, 0, -1, 0, -1, 0);
      step(12);
      j1 = 16'h0000;
      step(3);
      push_coin("coin_repress", 16, 3, 10, 0, -1, 13);
      j1 = 16'h0080;
      step(16);
      j1 = 16'h0000;
      for (int i = 0; i < 40 && exp_q.size() > 0; i++) step(1);
      if (exp_q.size() > 0) begin
         checks++;
         errors++;
         $display("FAIL drain: %0d entries left expected 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
